// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Machine-mode trap controller for the 16-entry CSR file. It accepts one of
//   three requests from IDLE: a WB-stage exception, an enabled external
//   interrupt, or an mret. It then drives the two CSR write ports and the
//   trap_begin/trap_end status pulses. Finally it redirects fetch to mtvec
//   for a trap, or to mepc for an mret.
//
//   Ports
//     clk, rst                  clock; synchronous active-low reset
//     exc_valid/cause/pc/tval   exception request from WB
//     mret_valid                mret request from WB
//     irq, irq_pc               level-sensitive external interrupt and resume PC
//     mstatus, mtvec, mepc      live CSR values (only mstatus[3] = MIE is used)
//     busy, flush               pipeline stall / kill (combinational on accept)
//     csr_w/waddr/wdata         CSR write port 1, mode csr_wsc_mode (always write)
//     csr_w2/waddr2/wdata2      CSR write port 2, mode csr_wsc_mode2 (always write)
//     trap_begin, trap_end      one-cycle mstatus stacking pulses
//     redirect, redirect_pc     one-cycle fetch redirect and its target
//
//   Timing: a trap is accepted in cycle 0. The sequencer is in T_CAUSE in
//   cycle 1, in T_TVAL in cycle 2 and in JUMP in cycle 3. An mret is accepted
//   in cycle 0, is in RET in cycle 1 and is in JUMP in cycle 2.
module trap_sequencer #(
   parameter logic [11:0] MEPC_ADDR   = 12'h341,
   parameter logic [11:0] MCAUSE_ADDR = 12'h342,
   parameter logic [11:0] MTVAL_ADDR  = 12'h343,
   parameter logic [31:0] INT_CAUSE   = 32'h8000_000B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [31:0] exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic        irq,
   input  logic [31:0] irq_pc,
   input  logic [31:0] mstatus,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        busy,
   output logic        flush,
   output logic        csr_w,
   output logic [11:0] waddr,
   output logic [31:0] wdata,
   output logic [1:0]  csr_wsc_mode,
   output logic        csr_w2,
   output logic [11:0] waddr2,
   output logic [31:0] wdata2,
   output logic [1:0]  csr_wsc_mode2,
   output logic        trap_begin,
   output logic        trap_end,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      T_CAUSE = 3'd1,
      T_TVAL  = 3'd2,
      RET     = 3'd3,
      JUMP    = 3'd4
   } state_t;

   state_t      state_r;
   logic        jump_mret_r;   // JUMP flavour: 1 = return to mepc, 0 = trap to mtvec
   logic [31:0] tval_r;        // trap value held until the T_TVAL write

   logic take_exc_s;
   logic take_irq_s;
   logic take_mret_s;
   logic accept_s;

   // Only MIE and the aligned part of mtvec are used.
   logic unused_bits_s;
   assign unused_bits_s = ^{mstatus[31:4], mstatus[2:0], mtvec[1:0]};

   // Both ports always operate in plain-write mode.
   assign csr_wsc_mode  = 2'b01;
   assign csr_wsc_mode2 = 2'b01;

   // Request arbitration in IDLE: exception > enabled interrupt > mret.
   // Gated by rst so that nothing is accepted in a reset cycle.
   always_comb begin
      take_exc_s  = 1'b0;
      take_irq_s  = 1'b0;
      take_mret_s = 1'b0;
      if (rst && (state_r == IDLE)) begin
         if (exc_valid) begin
            take_exc_s = 1'b1;
         end else if (irq && mstatus[3]) begin
            take_irq_s = 1'b1;
         end else if (mret_valid) begin
            take_mret_s = 1'b1;
         end else begin
            take_mret_s = 1'b0;
         end
      end else begin
         take_exc_s = 1'b0;
      end
   end

   assign accept_s = take_exc_s | take_irq_s | take_mret_s;
   // Stall and flush must act in the accepting cycle itself, so these are combinational.
   assign busy     = (state_r != IDLE) | accept_s;
   assign flush    = accept_s;

   // Redirect target is taken from the live CSR values in the JUMP cycle.
   always_comb begin
      redirect_pc = 32'h0000_0000;
      if (redirect) begin
         if (jump_mret_r) begin
            redirect_pc = mepc;
         end else begin
            redirect_pc = {mtvec[31:2], 2'b00};
         end
      end else begin
         redirect_pc = 32'h0000_0000;
      end
   end

   // Sequencer FSM. Port writes and pulses are registered on the transition
   // into the state that owns them. mepc and mcause are therefore written
   // straight from the request in T_CAUSE. Only tval needs holding for one
   // extra cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         jump_mret_r <= 1'b0;
         tval_r      <= 32'h0000_0000;
         csr_w       <= 1'b0;
         waddr       <= 12'h000;
         wdata       <= 32'h0000_0000;
         csr_w2      <= 1'b0;
         waddr2      <= 12'h000;
         wdata2      <= 32'h0000_0000;
         trap_begin  <= 1'b0;
         trap_end    <= 1'b0;
         redirect    <= 1'b0;
      end else begin
         csr_w      <= 1'b0;
         waddr      <= 12'h000;
         wdata      <= 32'h0000_0000;
         csr_w2     <= 1'b0;
         waddr2     <= 12'h000;
         wdata2     <= 32'h0000_0000;
         trap_begin <= 1'b0;
         trap_end   <= 1'b0;
         redirect   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (take_exc_s) begin
                  state_r <= T_CAUSE;
                  tval_r  <= exc_tval;
                  csr_w   <= 1'b1;
                  waddr   <= MEPC_ADDR;
                  wdata   <= exc_pc;
                  csr_w2  <= 1'b1;
                  waddr2  <= MCAUSE_ADDR;
                  wdata2  <= exc_cause;
               end else if (take_irq_s) begin
                  state_r <= T_CAUSE;
                  tval_r  <= 32'h0000_0000;
                  csr_w   <= 1'b1;
                  waddr   <= MEPC_ADDR;
                  wdata   <= irq_pc;
                  csr_w2  <= 1'b1;
                  waddr2  <= MCAUSE_ADDR;
                  wdata2  <= INT_CAUSE;
               end else if (take_mret_s) begin
                  state_r  <= RET;
                  trap_end <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            T_CAUSE: begin
               state_r    <= T_TVAL;
               csr_w      <= 1'b1;
               waddr      <= MTVAL_ADDR;
               wdata      <= tval_r;
               trap_begin <= 1'b1;
            end
            T_TVAL: begin
               state_r     <= JUMP;
               jump_mret_r <= 1'b0;
               redirect    <= 1'b1;
            end
            RET: begin
               state_r     <= JUMP;
               jump_mret_r <= 1'b1;
               redirect    <= 1'b1;
            end
            JUMP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
